// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, index width
// and the default serializer baud divisor.
package uart_tx_arbiter_pkg;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned CLKS_PER_BIT = 100000000 / 115200;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_BUSY  = 4'b0100,
        ST_GAP   = 4'b1000
    } arb_state_e;

    // Successor requester index, wrapping at num_req.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input int unsigned      num_req);
        logic [IDX_W-1:0] res;
        if (32'(idx) + 32'd1 >= num_req) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + IDX_W'(1'b1);
        end
        return res;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr,
// searching upward with wrap.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               any
);
    // Scan offsets from farthest to nearest so the nearest valid entry is written last.
    always_comb begin
        sel = {IDX_W{1'b0}};
        any = 1'b0;
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (valid[k] && (((int'(ptr) + off) % int'(NUM_REQ)) == k)) begin
                    sel = IDX_W'(k);
                    any = 1'b1;
                end else begin
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx serializer between
// several byte-stream requesters, with an owner-stall watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned GAP_CLKS     = 0,
    parameter int unsigned HOLD_TIMEOUT = 100000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_dv,
    output logic [7:0]           tx_byte,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 locked,
    output logic [15:0]          msg_count,
    output logic                 timeout_flag
);
    localparam int unsigned WD_W  = (HOLD_TIMEOUT > 32'd0) ? $clog2(HOLD_TIMEOUT + 32'd1) : 1;
    localparam int unsigned GAP_W = (GAP_CLKS > 32'd0) ? $clog2(GAP_CLKS + 32'd1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((HOLD_TIMEOUT > 32'd0) ? HOLD_TIMEOUT - 32'd1 : 32'd0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 32'd0) ? GAP_CLKS - 32'd1 : 32'd0);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
            $error("uart_tx_arbiter: NUM_REQ must be in 2..4");
        end
    endgenerate

    arb_state_e         state_r, state_nxt_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [WD_W-1:0]    wd_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [NUM_REQ-1:0] eligible_s;
    logic [IDX_W-1:0]   pick_sel_s;
    logic               pick_any_s;
    logic               accept_s;
    logic [7:0]         sel_byte_s;
    logic               sel_last_s;
    logic               owner_valid_s;
    logic               wd_run_s;
    logic               wd_expire_s;

    // While locked only the owner is eligible; also mux the picked lane's byte/last.
    always_comb begin
        eligible_s    = {NUM_REQ{1'b0}};
        sel_byte_s    = 8'h00;
        sel_last_s    = 1'b0;
        owner_valid_s = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!locked || grant_idx == IDX_W'(k)) begin
                eligible_s[k] = req_valid[k];
            end else begin
                eligible_s[k] = 1'b0;
            end
            if (pick_sel_s == IDX_W'(k)) begin
                sel_byte_s = req_byte[8*k +: 8];
                sel_last_s = req_last[k];
            end else begin
            end
            if (grant_idx == IDX_W'(k)) begin
                owner_valid_s = req_valid[k];
            end else begin
            end
        end
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid (eligible_s),
        .ptr   (ptr_r),
        .sel   (pick_sel_s),
        .any   (pick_any_s)
    );

    assign wd_run_s    = (state_r == ST_IDLE) && locked && !owner_valid_s;
    assign wd_expire_s = wd_run_s && (wd_cnt_r == WD_LAST);

    // Next-state logic and the combinational single-lane accept handshake.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = {NUM_REQ{1'b0}};
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!reset && !tx_active && pick_any_s) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_START;
                    for (int k = 0; k < int'(NUM_REQ); k++) begin
                        req_ready[k] = (pick_sel_s == IDX_W'(k));
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_BUSY;
            ST_BUSY: begin
                if (tx_done) begin
                    state_nxt_s = (GAP_CLKS > 32'd0) ? ST_GAP : ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte capture, ownership, message counting and watchdog release.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_dv        <= 1'b0;
            tx_byte      <= 8'h00;
            grant_idx    <= {IDX_W{1'b0}};
            locked       <= 1'b0;
            msg_count    <= 16'd0;
            timeout_flag <= 1'b0;
            ptr_r        <= {IDX_W{1'b0}};
        end else begin
            tx_dv <= accept_s;
            if (accept_s) begin
                tx_byte   <= sel_byte_s;
                grant_idx <= pick_sel_s;
                locked    <= !sel_last_s;
                if (sel_last_s) begin
                    msg_count <= msg_count + 16'd1;
                    ptr_r     <= next_idx(pick_sel_s, NUM_REQ);
                end else begin
                end
            end else if (wd_expire_s) begin
                locked       <= 1'b0;
                timeout_flag <= 1'b1;
                ptr_r        <= next_idx(grant_idx, NUM_REQ);
            end else begin
            end
        end
    end

    // Owner-stall watchdog and inter-byte gap counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r  <= {WD_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
        end else begin
            if (!wd_run_s || wd_expire_s) begin
                wd_cnt_r <= {WD_W{1'b0}};
            end else begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
            end
            if (state_r != ST_GAP) begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end else begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
            end
        end
    end
endmodule
